// File: rtl/cdc_arb_pkg.sv
// Shared types and constants for the round-robin arbiter in front of the 2-phase CDC source.
package cdc_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    localparam int          STAT_CNT_W   = 16;
    localparam logic [15:0] STAT_CNT_MAX = 16'hFFFF;

    // (a + b) mod n, valid when both operands are already below n.
    function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                             input int unsigned n);
        int unsigned s;
        s = a + b;
        if (s >= n) s = s - n;
        return s;
    endfunction

endpackage

// File: rtl/cdc_2phase_src_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: rotate requests by the pointer, priority-encode, rotate back.
module rr_pick
    import cdc_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic               gnt_valid_o,
    output logic [ID_W-1:0]    gnt_idx_o
);

    logic [NUM_REQ-1:0] w_rot;
    logic               w_found;
    logic [ID_W-1:0]    w_pos;

    always_comb begin
        w_rot   = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_rot[j] = req_i[ID_W'(wrap_add(j, 32'(ptr_i), NUM_REQ))];
        end
        // lowest rotated position is the requester closest to the pointer
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && w_rot[j]) begin
                w_found = 1'b1;
                w_pos   = ID_W'(j);
            end
        end
    end

    assign gnt_valid_o = w_found;
    assign gnt_idx_o   = ID_W'(wrap_add(32'(w_pos), 32'(ptr_i), NUM_REQ));

endmodule

// File: rtl/cdc_2phase_src_rr_arbiter.sv
// Round-robin arbiter sharing one 2-phase CDC source channel; holds one beat until the CDC takes it.
// Optional per-requester grant counters enabled by defining CDC_ARB_STATS_EN.
module cdc_2phase_src_rr_arbiter
    import cdc_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 34,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [DATA_W-1:0]         data_o,
    output logic [ID_W-1:0]           gnt_id_o,
    input  logic [ID_W-1:0]           stat_sel_i,
    output logic [15:0]               stat_cnt_o
);

    arb_state_e         r_state;
    logic               r_valid;
    logic [DATA_W-1:0]  r_data;
    logic [ID_W-1:0]    r_gnt_id;
    logic [ID_W-1:0]    r_rr_ptr;

    logic               w_gnt_valid;
    logic [ID_W-1:0]    w_gnt_idx;
    logic               w_accept;
    logic               w_win;
    logic [DATA_W-1:0]  w_win_data;
    logic [ID_W-1:0]    w_ptr_next;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req_i       (req_valid_i),
        .ptr_i       (r_rr_ptr),
        .gnt_valid_o (w_gnt_valid),
        .gnt_idx_o   (w_gnt_idx)
    );

    // A held beat leaves the slot exactly when the CDC takes it, so refill in the same cycle.
    assign w_accept   = !clear_i && ((r_state == ARB_IDLE) || ready_i);
    assign w_win      = w_accept && w_gnt_valid;
    assign w_win_data = req_data_i[w_gnt_idx*DATA_W +: DATA_W];
    assign w_ptr_next = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    always_comb begin
        req_ready_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_win && (w_gnt_idx == ID_W'(k))) req_ready_o[k] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ARB_IDLE;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_gnt_id <= '0;
            r_rr_ptr <= '0;
        end else if (clear_i) begin
            r_state <= ARB_IDLE;
            r_valid <= 1'b0;
        end else if (w_win) begin
            r_state  <= ARB_HOLD;
            r_valid  <= 1'b1;
            r_data   <= w_win_data;
            r_gnt_id <= w_gnt_idx;
            r_rr_ptr <= w_ptr_next;
        end else if ((r_state == ARB_HOLD) && ready_i) begin
            r_state <= ARB_IDLE;
            r_valid <= 1'b0;
        end
    end

    assign valid_o  = r_valid;
    assign data_o   = r_data;
    assign gnt_id_o = r_gnt_id;

`ifdef CDC_ARB_STATS_EN
    logic [STAT_CNT_W-1:0] r_cnt [NUM_REQ];

    // Counters survive clear_i so statistics span flushes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_REQ; k++) r_cnt[k] <= '0;
        end else if (w_win && (r_cnt[w_gnt_idx] != STAT_CNT_MAX)) begin
            r_cnt[w_gnt_idx] <= r_cnt[w_gnt_idx] + 1'b1;
        end
    end

    always_comb begin
        stat_cnt_o = '0;
        if (32'(stat_sel_i) < NUM_REQ) stat_cnt_o = r_cnt[stat_sel_i];
    end
`else
    logic w_unused_stat_sel;
    assign w_unused_stat_sel = ^stat_sel_i;
    assign stat_cnt_o        = '0;
`endif

endmodule

// File: tb/tb_cdc_2phase_src_rr_arbiter.sv
// Directed bench for cdc_2phase_src_rr_arbiter (NUM_REQ=4, DATA_W=34); stats checks follow CDC_ARB_STATS_EN.
module tb_cdc_2phase_src_rr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 34;
    localparam int ID_W    = 2;

    logic                      clk_i = 1'b0;
    logic                      rst_i;
    logic                      clear_i;
    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic [NUM_REQ*DATA_W-1:0] req_data_i;
    logic                      valid_o;
    logic                      ready_i;
    logic [DATA_W-1:0]         data_o;
    logic [ID_W-1:0]           gnt_id_o;
    logic [ID_W-1:0]           stat_sel_i;
    logic [15:0]               stat_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    cdc_2phase_src_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_data_i  (req_data_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .gnt_id_o    (gnt_id_o),
        .stat_sel_i  (stat_sel_i),
        .stat_cnt_o  (stat_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] beat(input int k);
        logic [1:0] hi;
        hi = 2'(k);
        return {hi, 32'hC0DE_0000 + 32'(k)};
    endfunction

    function automatic logic [63:0] exp_stat(input int v);
`ifdef CDC_ARB_STATS_EN
        return 64'(v);
`else
        return 64'(v) & 64'h0;
`endif
    endfunction

    initial begin
        rst_i       = 1'b1;
        clear_i     = 1'b0;
        req_valid_i = '0;
        req_data_i  = '0;
        ready_i     = 1'b0;
        stat_sel_i  = '0;

        // 1. reset
        tick();
        tick();
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_req_ready", 64'(req_ready_o), 64'd0);
        chk("rst_data", 64'(data_o), 64'd0);
        chk("rst_gnt_id", 64'(gnt_id_o), 64'd0);
        for (int s = 0; s < NUM_REQ; s++) begin
            stat_sel_i = ID_W'(s);
            #1;
            chk("rst_stat", 64'(stat_cnt_o), 64'd0);
        end
        rst_i = 1'b0;

        // 2. single requester
        req_data_i[2*DATA_W +: DATA_W] = 34'h2_DEAD_BEEF;
        req_data_i[0*DATA_W +: DATA_W] = 34'h1_1111_1111;
        req_valid_i = 4'b0100;
        ready_i     = 1'b1;
        #1;
        chk("single_req_ready", 64'(req_ready_o), 64'b0100);
        tick();
        chk("single_valid", 64'(valid_o), 64'd1);
        chk("single_data", 64'(data_o), 64'h2_DEAD_BEEF);
        chk("single_gnt_id", 64'(gnt_id_o), 64'd2);
        req_valid_i = '0;
        #1;
        chk("hold_empty_req_ready", 64'(req_ready_o), 64'd0);
        tick();
        chk("hold_exit_valid", 64'(valid_o), 64'd0);

        // reset again so the pointer starts at 0 for the round-robin sequence
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;

        // 3. round robin, all valid, ready held high
        for (int k = 0; k < NUM_REQ; k++) req_data_i[k*DATA_W +: DATA_W] = beat(k);
        req_valid_i = 4'hF;
        ready_i     = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("rr_req_ready", 64'(req_ready_o), 64'(1) << (i % 4));
            tick();
            chk("rr_valid", 64'(valid_o), 64'd1);
            chk("rr_gnt_id", 64'(gnt_id_o), 64'(i % 4));
            chk("rr_data", 64'(data_o), 64'(beat(i % 4)));
        end

        // 4. back-pressure while holding requester 3's beat
        ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_req_ready", 64'(req_ready_o), 64'd0);
            tick();
            chk("bp_valid", 64'(valid_o), 64'd1);
            chk("bp_gnt_id", 64'(gnt_id_o), 64'd3);
            chk("bp_data", 64'(data_o), 64'(beat(3)));
        end
        ready_i = 1'b1;
        #1;
        chk("bp_release_req_ready", 64'(req_ready_o), 64'b0001);
        tick();
        chk("bp_release_gnt_id", 64'(gnt_id_o), 64'd0);
        chk("bp_release_data", 64'(data_o), 64'(beat(0)));

        // 5. clear in HOLD with ready low; pointer is now 1
        ready_i = 1'b0;
        clear_i = 1'b1;
        #1;
        chk("clr_req_ready", 64'(req_ready_o), 64'd0);
        tick();
        chk("clr_valid", 64'(valid_o), 64'd0);
        chk("clr_gnt_kept", 64'(gnt_id_o), 64'd0);
        chk("clr_data_kept", 64'(data_o), 64'(beat(0)));
        clear_i = 1'b0;
        #1;
        chk("post_clr_req_ready", 64'(req_ready_o), 64'b0010);
        tick();
        chk("post_clr_valid", 64'(valid_o), 64'd1);
        chk("post_clr_gnt_id", 64'(gnt_id_o), 64'd1);

        // 6. stats: requesters 0 and 1 have 3 grants, 2 and 3 have 2
        stat_sel_i = 2'd1;
        #1;
        chk("stat_req1", 64'(stat_cnt_o), exp_stat(3));
        stat_sel_i = 2'd0;
        #1;
        chk("stat_req0", 64'(stat_cnt_o), exp_stat(3));
        stat_sel_i = 2'd2;
        #1;
        chk("stat_req2", 64'(stat_cnt_o), exp_stat(2));

`ifdef CDC_ARB_STATS_EN
        // drive requester 1 past saturation
        req_valid_i = 4'b0010;
        ready_i     = 1'b1;
        repeat (65540) tick();
        stat_sel_i = 2'd1;
        #1;
        chk("stat_saturate", 64'(stat_cnt_o), 64'hFFFF);
        stat_sel_i = 2'd0;
        #1;
        chk("stat_req0_after_sat", 64'(stat_cnt_o), 64'd3);
        req_valid_i = 4'hF;
        ready_i     = 1'b0;
`endif

        // rst_i and clear_i together: reset wins and zeroes data/id
        rst_i   = 1'b1;
        clear_i = 1'b1;
        tick();
        chk("rst_clr_valid", 64'(valid_o), 64'd0);
        chk("rst_clr_gnt_id", 64'(gnt_id_o), 64'd0);
        chk("rst_clr_data", 64'(data_o), 64'd0);
        rst_i   = 1'b0;
        clear_i = 1'b0;
        ready_i = 1'b0;
        #1;
        chk("rst_clr_next_req_ready", 64'(req_ready_o), 64'b0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
